// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I memory-op encodings and responder state type
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - byte-lane steering, load extension and misalign/illegal detection
module load_store_align
   import riscv_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext,
   output logic        err
);

   logic [31:0] rshift;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   always_comb begin
      rshift = rword >> {addr_lo, 3'b000};
      rbyte  = rshift[7:0];
      rhalf  = addr_lo[1] ? rword[31:16] : rword[15:0];
   end

   always_comb begin
      be        = 4'b0000;
      wdata_sh  = 32'h0;
      rdata_ext = 32'h0;
      err       = 1'b0;
      if (we) begin
         // Replicating the source across lanes lets the byte enables alone pick the target lane.
         case (funct3)
            F3_B: begin
               be       = 4'b0001 << addr_lo;
               wdata_sh = {4{wdata[7:0]}};
            end
            F3_H: begin
               err      = addr_lo[0];
               be       = addr_lo[1] ? 4'b1100 : 4'b0011;
               wdata_sh = {2{wdata[15:0]}};
            end
            F3_W: begin
               err      = (addr_lo != 2'b00);
               be       = 4'b1111;
               wdata_sh = wdata;
            end
            default: err = 1'b1;
         endcase
         if (err) be = 4'b0000;
      end else begin
         case (funct3)
            F3_B:  rdata_ext = {{24{rbyte[7]}}, rbyte};
            F3_BU: rdata_ext = {24'h0, rbyte};
            F3_H: begin
               err       = addr_lo[0];
               rdata_ext = {{16{rhalf[15]}}, rhalf};
            end
            F3_HU: begin
               err       = addr_lo[0];
               rdata_ext = {16'h0, rhalf};
            end
            F3_W: begin
               err       = (addr_lo != 2'b00);
               rdata_ext = rword;
            end
            default: err = 1'b1;
         endcase
         if (err) rdata_ext = 32'h0;
      end
   end

endmodule

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - MEM-stage data memory responder with programmable wait states
module data_mem_resp
   import riscv_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

   mem_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic        op_we;
   logic [2:0]  op_f3;
   logic [31:0] op_addr;
   logic [31:0] op_wdata;
   logic [AW-1:0] op_idx;
   logic [31:0] op_rword;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_rdata;
   logic        al_err;
   logic        mem_we;

   // With zero wait states the op resolves on the accept edge, so it must come straight from the inputs.
   always_comb begin
      if (state_q == ST_IDLE) begin
         op_we    = req_we;
         op_f3    = req_funct3;
         op_addr  = req_addr;
         op_wdata = req_wdata;
      end else begin
         op_we    = we_q;
         op_f3    = f3_q;
         op_addr  = addr_q;
         op_wdata = wdata_q;
      end
      op_idx   = op_addr[AW+1:2];
      op_rword = mem[op_idx];
   end

   load_store_align u_align (
      .we        (op_we),
      .funct3    (op_f3),
      .addr_lo   (op_addr[1:0]),
      .wdata     (op_wdata),
      .rword     (op_rword),
      .be        (al_be),
      .wdata_sh  (al_wdata),
      .rdata_ext (al_rdata),
      .err       (al_err)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      f3_d        = f3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = 32'h0;
      rsp_err_d   = 1'b0;
      mem_we      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (WAIT_STATES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CW'(WAIT_STATES - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_RESP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_RESP && state_q != ST_RESP) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = al_err;
         rsp_rdata_d = op_we ? 32'h0 : al_rdata;
         mem_we      = op_we && !al_err;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         f3_q        <= 3'b000;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         f3_q        <= f3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Array deliberately has no reset so contents survive a pipeline reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (al_be[b]) mem[op_idx][8*b +: 8] <= al_wdata[8*b +: 8];
         end
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - directed self-checking bench for data_mem_resp
module tb_data_mem_resp;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst1, rst3;
   logic        vld1, vld3;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rdy1, rdy3, rv1, rv3, err1, err3;
   logic [31:0] rd1, rd3;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u1 (
      .clk(clk), .rst(rst1), .req_valid(vld1), .req_ready(rdy1), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1));

   data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u3 (
      .clk(clk), .rst(rst3), .req_valid(vld3), .req_ready(rdy3), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input int sel); return sel ? rdy3 : rdy1; endfunction
   function automatic logic rvl(input int sel); return sel ? rv3 : rv1; endfunction

   task automatic accept(input int sel, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input string tag);
      @(negedge clk);
      chk({tag, ":ready"}, {31'h0, rdy(sel)}, 32'h1);
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      if (sel != 0) vld3 = 1'b1; else vld1 = 1'b1;
      @(posedge clk);
      #1;
      vld1 = 1'b0; vld3 = 1'b0;
      req_we = 1'b1; req_funct3 = 3'b000; req_addr = $urandom; req_wdata = $urandom;
   endtask

   task automatic op(input int sel, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input string tag);
      int n;
      accept(sel, we, f3, a, wd, tag);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         chk({tag, ":busy"}, {31'h0, rdy(sel)}, 32'h0);
      end while (!rvl(sel) && n < 10);
      chk({tag, ":latency"}, n, (sel != 0) ? 32'd4 : 32'd2);
      chk({tag, ":rdata"}, sel ? rd3 : rd1, exp_rd);
      chk({tag, ":err"}, {31'h0, sel ? err3 : err1}, {31'h0, exp_err});
      @(negedge clk);
      chk({tag, ":pulse"}, {31'h0, rvl(sel)}, 32'h0);
      chk({tag, ":rdata0"}, sel ? rd3 : rd1, 32'h0);
      chk({tag, ":idle"}, {31'h0, rdy(sel)}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      rst1 = 1'b0; rst3 = 1'b0; vld1 = 1'b0; vld3 = 1'b0;
      req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst:ready", {31'h0, rdy1}, 32'h1);
      chk("rst:valid", {31'h0, rv1}, 32'h0);
      chk("rst:rdata", rd1, 32'h0);
      chk("rst:err", {31'h0, err1}, 32'h0);
      rst1 = 1'b1; rst3 = 1'b1;

      op(0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, "sw10");
      op(0, 1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, "lw10");
      op(0, 1'b1, F3_B,  32'h11, 32'hFFFFFF7F, 32'h0,        1'b0, "sb11");
      op(0, 1'b0, F3_B,  32'h11, 32'h0,        32'h0000007F, 1'b0, "lb11");
      op(0, 1'b0, F3_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, "lb13");
      op(0, 1'b0, F3_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0, "lbu13");
      op(0, 1'b0, F3_W,  32'h10, 32'h0,        32'hDEAD7FEF, 1'b0, "lw10b");
      op(0, 1'b1, F3_W,  32'h20, 32'h11223344, 32'h0,        1'b0, "sw20");
      op(0, 1'b1, F3_H,  32'h22, 32'hFFFF8001, 32'h0,        1'b0, "sh22");
      op(0, 1'b0, F3_H,  32'h22, 32'h0,        32'hFFFF8001, 1'b0, "lh22");
      op(0, 1'b0, F3_HU, 32'h22, 32'h0,        32'h00008001, 1'b0, "lhu22");
      op(0, 1'b0, F3_W,  32'h12, 32'h0,        32'h0,        1'b1, "lw12err");
      op(0, 1'b1, F3_H,  32'h23, 32'h5555AAAA, 32'h0,        1'b1, "sh23err");
      op(0, 1'b1, 3'b011, 32'h20, 32'h0,       32'h0,        1'b1, "st011err");
      op(0, 1'b0, 3'b110, 32'h20, 32'h0,       32'h0,        1'b1, "ld110err");
      op(0, 1'b0, F3_W,  32'h20, 32'h0,        32'h80013344, 1'b0, "lw20");
      op(0, 1'b0, F3_H,  32'h20, 32'h0,        32'h00003344, 1'b0, "lh20");
      op(0, 1'b0, F3_BU, 32'h21, 32'h0,        32'h00000033, 1'b0, "lbu21");
      op(0, 1'b0, F3_W,  32'h1010, 32'h0,      32'hDEAD7FEF, 1'b0, "lwwrap");

      // Reset while the response is on the bus must clear outputs without a clock edge.
      accept(0, 1'b0, F3_W, 32'h10, 32'h0, "rstresp");
      seen = 0;
      for (int i = 0; i < 6 && seen == 0; i++) begin
         @(negedge clk);
         if (rv1) seen = 1;
      end
      chk("rstresp:seen", seen, 32'd1);
      #1 rst1 = 1'b0;
      #1;
      chk("rstresp:ready", {31'h0, rdy1}, 32'h1);
      chk("rstresp:valid", {31'h0, rv1}, 32'h0);
      chk("rstresp:rdata", rd1, 32'h0);
      @(negedge clk) rst1 = 1'b1;

      op(1, 1'b1, F3_W, 32'h30, 32'hCAFEF00D, 32'h0,        1'b0, "ws3:sw30");
      accept(1, 1'b1, F3_W, 32'h30, 32'h12345678, "ws3:rstwait");
      @(posedge clk);
      #1 rst3 = 1'b0;
      #1;
      chk("ws3:rst:ready", {31'h0, rdy3}, 32'h1);
      chk("ws3:rst:valid", {31'h0, rv3}, 32'h0);
      @(negedge clk) rst3 = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rv3) seen++;
      end
      chk("ws3:noresp", seen, 32'd0);
      op(1, 1'b0, F3_W, 32'h30, 32'h0,        32'hCAFEF00D, 1'b0, "ws3:lw30");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
